// File: rtl/lsu_axil_master.sv
// Load/store unit AXI4-Lite initiator: turns one core load/store request into a
// single dmem AR/R or AW/W/B transaction and returns one registered response.
module lsu_axil_master #(
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_misalign,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR,
    S_WR_RESP,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_misalign_q, rsp_misalign_d;
  logic [ADDR_W-1:0]   m_araddr_q, m_araddr_d;
  logic                m_arvalid_q, m_arvalid_d;
  logic                m_rready_q, m_rready_d;
  logic [ADDR_W-1:0]   m_awaddr_q, m_awaddr_d;
  logic                m_awvalid_q, m_awvalid_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
  logic                m_wvalid_q, m_wvalid_d;
  logic                m_bready_q, m_bready_d;

  logic                misalign_c;
  logic [STRB_W-1:0]   strb_c;
  logic [DATA_W-1:0]   lane_c;
  logic [DATA_W-1:0]   load_ext_c;
  logic                aw_pend_c;
  logic                w_pend_c;

  // Request decode: local alignment reject and LSB-justified write strobes.
  always_comb begin
    misalign_c = MISALIGN_CHECK &&
                 ((req_size == 2'b11) ||
                  (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00));
    unique case (req_size)
      2'b00:   strb_c = STRB_W'(4'b0001);
      2'b01:   strb_c = STRB_W'(4'b0011);
      default: strb_c = STRB_W'(4'b1111);
    endcase
  end

  // Read lane select and sign/zero extension of the returned word.
  always_comb begin
    lane_c = m_rdata >> {addr_lo_q, 3'b000};
    unique case (size_q)
      2'b00:   load_ext_c = {{24{~uns_q & lane_c[7]}},  lane_c[7:0]};
      2'b01:   load_ext_c = {{16{~uns_q & lane_c[15]}}, lane_c[15:0]};
      default: load_ext_c = lane_c;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    size_d         = size_q;
    uns_d          = uns_q;
    addr_lo_d      = addr_lo_q;
    req_ready_d    = req_ready_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    rsp_misalign_d = rsp_misalign_q;
    m_araddr_d     = m_araddr_q;
    m_arvalid_d    = m_arvalid_q;
    m_rready_d     = m_rready_q;
    m_awaddr_d     = m_awaddr_q;
    m_awvalid_d    = m_awvalid_q;
    m_wdata_d      = m_wdata_q;
    m_wstrb_d      = m_wstrb_q;
    m_wvalid_d     = m_wvalid_q;
    m_bready_d     = m_bready_q;
    aw_pend_c      = m_awvalid_q & ~m_awready;
    w_pend_c       = m_wvalid_q & ~m_wready;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          size_d      = req_size;
          uns_d       = req_unsigned;
          addr_lo_d   = req_addr[1:0];
          if (misalign_c) begin
            state_d        = S_RESP;
            rsp_valid_d    = 1'b1;
            rsp_err_d      = 1'b1;
            rsp_misalign_d = 1'b1;
            rsp_rdata_d    = '0;
          end else if (req_wen) begin
            state_d     = S_WR;
            m_awaddr_d  = req_addr;
            m_wdata_d   = req_wdata;
            m_wstrb_d   = strb_c;
            m_awvalid_d = 1'b1;
            m_wvalid_d  = 1'b1;
          end else begin
            state_d     = S_RD_ADDR;
            m_araddr_d  = req_addr;
            m_arvalid_d = 1'b1;
          end
        end
      end
      S_RD_ADDR: begin
        if (m_arready) begin
          state_d     = S_RD_DATA;
          m_arvalid_d = 1'b0;
          m_rready_d  = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (m_rvalid) begin
          state_d        = S_RESP;
          m_rready_d     = 1'b0;
          rsp_valid_d    = 1'b1;
          rsp_err_d      = (m_rresp != 2'b00);
          rsp_misalign_d = 1'b0;
          rsp_rdata_d    = (m_rresp != 2'b00) ? '0 : load_ext_c;
        end
      end
      S_WR: begin
        // AW and W complete independently; move on once neither is pending.
        m_awvalid_d = aw_pend_c;
        m_wvalid_d  = w_pend_c;
        if (!aw_pend_c && !w_pend_c) begin
          state_d    = S_WR_RESP;
          m_bready_d = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (m_bvalid) begin
          state_d        = S_RESP;
          m_bready_d     = 1'b0;
          rsp_valid_d    = 1'b1;
          rsp_err_d      = (m_bresp != 2'b00);
          rsp_misalign_d = 1'b0;
          rsp_rdata_d    = '0;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      size_q         <= '0;
      uns_q          <= 1'b0;
      addr_lo_q      <= '0;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      rsp_misalign_q <= 1'b0;
      m_araddr_q     <= '0;
      m_arvalid_q    <= 1'b0;
      m_rready_q     <= 1'b0;
      m_awaddr_q     <= '0;
      m_awvalid_q    <= 1'b0;
      m_wdata_q      <= '0;
      m_wstrb_q      <= '0;
      m_wvalid_q     <= 1'b0;
      m_bready_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      addr_lo_q      <= addr_lo_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      rsp_misalign_q <= rsp_misalign_d;
      m_araddr_q     <= m_araddr_d;
      m_arvalid_q    <= m_arvalid_d;
      m_rready_q     <= m_rready_d;
      m_awaddr_q     <= m_awaddr_d;
      m_awvalid_q    <= m_awvalid_d;
      m_wdata_q      <= m_wdata_d;
      m_wstrb_q      <= m_wstrb_d;
      m_wvalid_q     <= m_wvalid_d;
      m_bready_q     <= m_bready_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_misalign = rsp_misalign_q;
  assign m_araddr     = m_araddr_q;
  assign m_arvalid    = m_arvalid_q;
  assign m_rready     = m_rready_q;
  assign m_awaddr     = m_awaddr_q;
  assign m_awvalid    = m_awvalid_q;
  assign m_wdata      = m_wdata_q;
  assign m_wstrb      = m_wstrb_q;
  assign m_wvalid     = m_wvalid_q;
  assign m_bready     = m_bready_q;

  // Handshake rules: valids hold with stable payload until ready.
  a_ar_hold: assert property (@(posedge clk) disable iff (rst)
    m_arvalid && !m_arready |=> m_arvalid && $stable(m_araddr));
  a_aw_hold: assert property (@(posedge clk) disable iff (rst)
    m_awvalid && !m_awready |=> m_awvalid && $stable(m_awaddr));
  a_w_hold: assert property (@(posedge clk) disable iff (rst)
    m_wvalid && !m_wready |=> m_wvalid && $stable(m_wdata) && $stable(m_wstrb));
  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_rdata) && $stable(rsp_err) && $stable(rsp_misalign));
  a_r_stray: assert property (@(posedge clk) disable iff (rst)
    m_rvalid |-> state_q == S_RD_DATA) else $fatal(1, "m_rvalid while no read data expected");
  a_b_stray: assert property (@(posedge clk) disable iff (rst)
    m_bvalid |-> state_q == S_WR_RESP) else $fatal(1, "m_bvalid while no write response expected");

endmodule

// File: tb/tb_lsu_axil_master.sv
// Scoreboard bench for lsu_axil_master: directed cases, a reset abort, then
// random loads/stores against a behavioural model and a randomly stalling slave.
module tb_lsu_axil_master;

  logic        clk, rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_misalign;
  logic [31:0] rsp_rdata;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]  m_rresp, m_bresp;
  logic [3:0]  m_wstrb;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          mis;
  } exp_t;

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          a_w;
    int          w_w;
    int          d_w;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_axil_master #(.MISALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_misalign(rsp_misalign),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_now();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  endtask

  // Behavioural reference: what the core should see for one request.
  function automatic exp_t model(input bit wen, input logic [31:0] addr, input logic [1:0] size,
                                 input bit uns, input logic [31:0] rdata, input logic [1:0] resp);
    exp_t        e;
    int unsigned idx;
    longint      v;
    logic [31:0] lane;
    idx     = 32'(addr % 4);
    e.rdata = 32'd0;
    e.err   = 1'b0;
    e.mis   = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && idx != 0);
    if (e.mis) begin
      e.err = 1'b1;
      return e;
    end
    if (resp != 2'd0) begin
      e.err = 1'b1;
      return e;
    end
    if (wen) return e;
    lane = rdata >> (8 * idx);
    if (size == 2'd0) begin
      v = longint'(lane % 256);
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = longint'(lane % 65536);
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(lane);
    end
    e.rdata = 32'(v);
    return e;
  endfunction

  task automatic slave_idle();
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0; m_rresp = 2'd0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'd0;
  endtask

  task automatic serve_read(input bus_t b);
    bit hs, ok;
    check("araddr", 64'(m_araddr), 64'(b.addr));
    for (int k = 0; k < b.a_w; k++) begin
      @(negedge clk);
      if (rst) begin slave_idle(); return; end
    end
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    if (rst) begin slave_idle(); return; end
    for (int k = 0; k < b.d_w; k++) begin
      @(negedge clk);
      if (rst) begin slave_idle(); return; end
    end
    m_rvalid = 1'b1; m_rdata = b.rdata; m_rresp = b.resp;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      hs = m_rready;
      @(negedge clk);
      if (rst) begin slave_idle(); return; end
      if (hs) begin ok = 1'b1; break; end
    end
    slave_idle();
    check("r_handshake", 64'(ok), 64'(1));
  endtask

  task automatic serve_write(input bus_t b);
    int k;
    bit aw_d, w_d, aw_f, w_f, extra, early, hs, ok;
    k = 0; aw_d = 0; w_d = 0; extra = 0; early = 0;
    while (!(aw_d && w_d)) begin
      if (k > 100) begin
        n_vec++; n_bad++;
        $display("FAIL wr_handshake: aw_done=%0b w_done=%0b after %0d cycles", aw_d, w_d, k);
        slave_idle();
        return;
      end
      m_awready = !aw_d && k >= b.a_w;
      m_wready  = !w_d && k >= b.w_w;
      aw_f = m_awready && m_awvalid;
      w_f  = m_wready && m_wvalid;
      if ((aw_d && m_awvalid) || (w_d && m_wvalid)) extra = 1'b1;
      if (m_bready) early = 1'b1;
      if (aw_f) check("awaddr", 64'(m_awaddr), 64'(b.addr));
      if (w_f) check("wstrb_wdata", 64'({m_wstrb, m_wdata}), 64'({b.strb, b.wdata}));
      @(negedge clk);
      if (rst) begin slave_idle(); return; end
      k++;
      if (aw_f) aw_d = 1'b1;
      if (w_f) w_d = 1'b1;
    end
    m_awready = 1'b0; m_wready = 1'b0;
    check("aw_w_once", 64'(extra), 64'(0));
    check("bready_early", 64'(early), 64'(0));
    check("bready_after", 64'(m_bready), 64'(1));
    for (int j = 0; j < b.d_w; j++) begin
      @(negedge clk);
      if (rst) begin slave_idle(); return; end
    end
    m_bvalid = 1'b1; m_bresp = b.resp;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      hs = m_bready;
      @(negedge clk);
      if (rst) begin slave_idle(); return; end
      if (hs) begin ok = 1'b1; break; end
    end
    slave_idle();
    check("b_handshake", 64'(ok), 64'(1));
  endtask

  // Slave: serves whichever channel the master opens, against the queued expectation.
  initial begin : slave
    bus_t b;
    bit   warned;
    warned = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (m_arvalid || m_awvalid || m_wvalid)) begin
        if (bus_q.size() == 0) begin
          if (!warned) begin
            n_vec++; n_bad++;
            $display("FAIL bus_unexpected: ar=%0b aw=%0b w=%0b with no transaction expected",
                     m_arvalid, m_awvalid, m_wvalid);
            warned = 1'b1;
          end
        end else begin
          b = bus_q.pop_front();
          check("bus_dir", 64'(!m_arvalid), 64'(b.wen));
          if (m_arvalid) serve_read(b);
          else serve_write(b);
        end
      end
    end
  end

  // Monitor: random rsp_ready, hold check, scoreboard compare on each handshake.
  initial begin : monitor
    exp_t        e;
    bit          held;
    logic [31:0] h_data;
    logic        h_err, h_mis;
    held = 1'b0; h_data = 32'd0; h_err = 1'b0; h_mis = 1'b0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (rst) begin
        held = 1'b0;
        continue;
      end
      if (held)
        check("rsp_hold", 64'({rsp_valid, rsp_err, rsp_misalign, rsp_rdata}),
              64'({1'b1, h_err, h_mis, h_data}));
      if (rsp_valid && rsp_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL rsp_unexpected: rdata=%h err=%0b mis=%0b", rsp_rdata, rsp_err, rsp_misalign);
        end else begin
          e = exp_q.pop_front();
          check("rsp", 64'({rsp_err, rsp_misalign, rsp_rdata}), 64'({e.err, e.mis, e.rdata}));
        end
      end else if (rsp_valid) begin
        held = 1'b1; h_data = rsp_rdata; h_err = rsp_err; h_mis = rsp_misalign;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic do_req(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input bit uns, input logic [31:0] rdata,
                        input logic [1:0] resp, input int a_w, input int w_w, input int d_w);
    exp_t e;
    bus_t b;
    int   t, lat, exp_lat;
    bit   bus_seen;
    e = model(wen, addr, size, uns, rdata, resp);
    exp_q.push_back(e);
    if (!e.mis) begin
      b.wen = wen; b.addr = addr; b.wdata = wdata; b.rdata = rdata; b.resp = resp;
      b.strb = 4'((1 << (1 << size)) - 1);
      b.a_w = a_w; b.w_w = w_w; b.d_w = d_w;
      bus_q.push_back(b);
    end
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    t = 0;
    while (!req_ready) begin
      @(negedge clk);
      t++;
      if (t > 300) begin
        $display("FAIL req_accept: req_ready stuck low");
        n_vec++; n_bad++;
        finish_now();
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; bus_seen = 1'b0;
    forever begin
      bus_seen |= m_arvalid | m_awvalid | m_wvalid;
      if (rsp_valid || lat >= 300) break;
      @(negedge clk);
      lat++;
    end
    if (e.mis) exp_lat = 1;
    else if (wen) exp_lat = 3 + ((a_w > w_w) ? a_w : w_w) + d_w;
    else exp_lat = 3 + a_w + d_w;
    check("latency", 64'(lat), 64'(exp_lat));
    if (e.mis) check("misalign_no_bus", 64'(bus_seen), 64'(0));
    t = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      t++;
      if (t > 300) begin
        $display("FAIL rsp_timeout: response never accepted");
        n_vec++; n_bad++;
        finish_now();
      end
    end
  endtask

  initial begin : stim
    bus_t        b;
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_size = 2'd0; req_unsigned = 1'b0;
    slave_idle();
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'(1));
    check("reset_ctrl", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                             rsp_valid, rsp_err, rsp_misalign}), 64'(0));
    check("reset_addr", 64'({m_araddr, m_awaddr}), 64'(0));
    check("reset_data", 64'({m_wstrb, m_wdata}) | 64'(rsp_rdata), 64'(0));
    rst = 1'b0;

    do_req(1'b0, 32'h8000_0003, 32'd0, 2'b00, 1'b0, 32'h80FF_1234, 2'b00, 0, 0, 2);
    do_req(1'b0, 32'h8000_0002, 32'd0, 2'b01, 1'b1, 32'hBEEF_0001, 2'b00, 0, 0, 0);
    do_req(1'b1, 32'h8000_0010, 32'h1234_ABCD, 2'b01, 1'b0, 32'd0, 2'b00, 0, 3, 0);
    do_req(1'b1, 32'h8000_0002, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'd0, 2'b00, 0, 0, 0);
    do_req(1'b0, 32'h8000_0000, 32'd0, 2'b10, 1'b0, 32'h1234_5678, 2'b10, 1, 0, 1);
    do_req(1'b1, 32'h8000_0004, 32'h0000_0055, 2'b10, 1'b0, 32'd0, 2'b10, 0, 0, 1);
    do_req(1'b0, 32'h8000_0001, 32'd0, 2'b11, 1'b0, 32'd0, 2'b00, 0, 0, 0);

    // Reset while AR is stalled: no response, clean restart.
    b.wen = 1'b0; b.addr = 32'h8000_0040; b.wdata = 32'd0; b.strb = 4'hF;
    b.rdata = 32'd0; b.resp = 2'd0; b.a_w = 1000; b.w_w = 0; b.d_w = 0;
    bus_q.push_back(b);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0040; req_size = 2'b10;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_arvalid", 64'(m_arvalid), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_state", 64'({m_arvalid, req_ready, rsp_valid}), 64'(3'b010));
    @(negedge clk);
    rst = 1'b0;
    bus_q.delete();
    exp_q.delete();
    do_req(1'b0, 32'h8000_0042, 32'd0, 2'b01, 1'b0, 32'h8001_7FFF, 2'b00, 0, 0, 0);

    for (int i = 0; i < 250; i++) begin
      r  = $urandom_range(0, 7);
      sz = (r < 7) ? 2'(r % 3) : 2'd3;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~(32'((1 << sz) - 1));
      do_req(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)), $urandom,
             ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'd0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    check("bus_queue_drained", 64'(bus_q.size()), 64'(0));
    finish_now();
  end

endmodule
